// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC sequencer: feature mux, sample/hold and
// N-bit capacitive DAC, one quantized feature per N+1 cycles.
module sar_adc_ctrl #(
  parameter int N        = 4,
  parameter int NUM_FEAT = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        cmp_in,
  output logic                        sample,
  output logic [N-1:0]                dac_code,
  output logic [$clog2(NUM_FEAT)-1:0] feat_sel,
  output logic [N-1:0]                quant_feat,
  output logic                        feat_valid,
  output logic                        frame_done,
  output logic                        busy
);

  localparam int BW = $clog2(N);
  localparam int FW = $clog2(NUM_FEAT);

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    CONVERT
  } state_t;

  state_t         state_q, state_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic [N-1:0]   acc_q, acc_d;
  logic [FW-1:0]  sel_q, sel_d;
  logic [N-1:0]   qf_q, qf_d;
  logic           fv_q, fv_d;
  logic           fd_q, fd_d;
  logic           last_sel;

  assign last_sel = (sel_q == FW'(NUM_FEAT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bit_q   <= '0;
      acc_q   <= '0;
      sel_q   <= '0;
      qf_q    <= '0;
      fv_q    <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      acc_q   <= acc_d;
      sel_q   <= sel_d;
      qf_q    <= qf_d;
      fv_q    <= fv_d;
      fd_q    <= fd_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    acc_d    = acc_q;
    sel_d    = sel_q;
    qf_d     = qf_q;
    fv_d     = 1'b0;
    fd_d     = 1'b0;
    sample   = 1'b0;
    dac_code = '0;
    busy     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_d = SAMPLE;
          sel_d   = '0;
        end
      end
      SAMPLE: begin
        sample  = 1'b1;
        busy    = 1'b1;
        state_d = CONVERT;
        bit_d   = BW'(N - 1);
        acc_d   = '0;
      end
      CONVERT: begin
        busy          = 1'b1;
        dac_code      = acc_q | (N'(1) << bit_q);
        acc_d[bit_q]  = cmp_in;
        bit_d         = bit_q - BW'(1);
        if (bit_q == '0) begin
          // final bit goes straight from the comparator into the result
          qf_d = {acc_q[N-1:1], cmp_in};
          fv_d = 1'b1;
          if (!last_sel) begin
            sel_d   = sel_q + FW'(1);
            state_d = SAMPLE;
          end else begin
            fd_d = 1'b1;
            if (en) begin
              sel_d   = '0;
              state_d = SAMPLE;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign feat_sel   = sel_q;
  assign quant_feat = qf_q;
  assign feat_valid = fv_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Scoreboard bench for sar_adc_ctrl: comparator model drives cmp_in,
// monitor checks every feat_valid and DAC trial against queued values.
module tb_sar_adc_ctrl;

  localparam int N  = 4;
  localparam int NF = 10;
  localparam int FW = $clog2(NF);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          cmp_in;
  logic          sample;
  logic [N-1:0]  dac_code;
  logic [FW-1:0] feat_sel;
  logic [N-1:0]  quant_feat;
  logic          feat_valid;
  logic          frame_done;
  logic          busy;

  sar_adc_ctrl #(.N(N), .NUM_FEAT(NF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .cmp_in     (cmp_in),
    .sample     (sample),
    .dac_code   (dac_code),
    .feat_sel   (feat_sel),
    .quant_feat (quant_feat),
    .feat_valid (feat_valid),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int mode = 0;
  int vconst = 0;
  int vin;
  int tab [NF] = '{1, 4, 7, 10, 13, 0, 3, 6, 9, 12};

  always_comb begin
    vin    = (mode == 0) ? vconst : (int'(feat_sel) * 3 + 1) % 16;
    cmp_in = (vin >= int'(dac_code));
  end

  typedef struct {
    int val;
    bit done;
    int stamp;
  } exp_t;

  exp_t exp_q [$];
  int   dac_q [$];
  bit   chk_dac = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (feat_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_feat_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("quant_feat", int'(quant_feat), e.val);
        chk("frame_done", int'(frame_done), int'(e.done));
        chk("valid_cycle", cyc, e.stamp);
      end
    end else if (frame_done) begin
      chk("stray_frame_done", 1, 0);
    end
    if (chk_dac && busy && !sample) begin
      if (dac_q.size() == 0)
        chk("unexpected_convert", 1, 0);
      else
        chk("dac_code", int'(dac_code), dac_q.pop_front());
    end
  end

  task automatic push_frame(input int t0, input int off, input int m,
                            input int vc, input int nfeat);
    exp_t e;
    for (int k = 0; k < nfeat; k++) begin
      e.val   = (m == 0) ? vc : tab[k];
      e.done  = (k == NF - 1);
      e.stamp = t0 + (off + k + 1) * (N + 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_dac(input int c0, input int c1,
                          input int c2, input int c3);
    for (int k = 0; k < NF; k++) begin
      dac_q.push_back(c0);
      dac_q.push_back(c1);
      dac_q.push_back(c2);
      dac_q.push_back(c3);
    end
  endtask

  task automatic begin_frame(output int t0);
    @(negedge clk);
    en = 1'b1;
    t0 = cyc + 1;
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("idle_timeout", 1, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_pulses(input int n, input int budget);
    int seen;
    seen = 0;
    for (int i = 0; i < budget && seen < n; i++) begin
      @(negedge clk);
      if (feat_valid) seen++;
    end
    if (seen < n) chk("pulse_timeout", seen, n);
  endtask

  task automatic drained();
    chk("exp_q_drained", exp_q.size(), 0);
    chk("dac_q_drained", dac_q.size(), 0);
  endtask

  task automatic const_frame(input int v, input int c0, input int c1,
                             input int c2, input int c3);
    int t0;
    mode    = 0;
    vconst  = v;
    chk_dac = 1'b1;
    push_dac(c0, c1, c2, c3);
    begin_frame(t0);
    push_frame(t0, 0, 0, v, NF);
    @(negedge clk);
    en = 1'b0;
    wait_idle(100);
    chk("busy_after_const", int'(busy), 0);
    chk("quant_hold", int'(quant_feat), v);
    drained();
    chk_dac = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  t0;
    bit  hit;
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sample", int'(sample), 0);
    chk("rst_dac", int'(dac_code), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_quant", int'(quant_feat), 0);
    chk("rst_valid", int'(feat_valid), 0);
    chk("rst_done", int'(frame_done), 0);
    chk("rst_sel", int'(feat_sel), 0);
    @(negedge clk);
    rst_n = 1'b1;

    const_frame(11, 8, 12, 10, 11);
    const_frame(0, 8, 4, 2, 1);
    const_frame(15, 8, 12, 14, 15);

    mode = 1;
    begin_frame(t0);
    push_frame(t0, 0, 1, 0, NF);
    @(negedge clk);
    en = 1'b0;
    wait_idle(100);
    chk("busy_after_frame", int'(busy), 0);
    chk("sel_hold_last", int'(feat_sel), NF - 1);
    drained();

    begin_frame(t0);
    push_frame(t0, 0, 1, 0, NF);
    push_frame(t0, NF, 1, 0, NF);
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (frame_done) begin
        hit = 1'b1;
        break;
      end
    end
    chk("b2b_done_seen", int'(hit), 1);
    chk("b2b_sample", int'(sample), 1);
    chk("b2b_sel", int'(feat_sel), 0);
    chk("b2b_busy", int'(busy), 1);
    en = 1'b0;
    wait_idle(100);
    chk("busy_after_b2b", int'(busy), 0);
    drained();

    begin_frame(t0);
    push_frame(t0, 0, 1, 0, NF);
    wait_pulses(3, 50);
    en = 1'b0;
    wait_idle(100);
    chk("busy_after_drop", int'(busy), 0);
    chk("sel_after_drop", int'(feat_sel), NF - 1);
    drained();

    begin_frame(t0);
    push_frame(t0, 0, 1, 0, 4);
    @(negedge clk);
    en = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (feat_sel == FW'(4) && busy && !sample) begin
        hit = 1'b1;
        break;
      end
    end
    chk("reach_feat4", int'(hit), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_sample", int'(sample), 0);
    chk("mid_rst_dac", int'(dac_code), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_valid", int'(feat_valid), 0);
    chk("mid_rst_done", int'(frame_done), 0);
    chk("mid_rst_quant", int'(quant_feat), 0);
    chk("mid_rst_sel", int'(feat_sel), 0);
    repeat (10) @(negedge clk);
    chk("idle_after_rst", int'(busy), 0);
    drained();

    begin_frame(t0);
    push_frame(t0, 0, 1, 0, NF);
    @(negedge clk);
    chk("restart_sample", int'(sample), 1);
    chk("restart_sel", int'(feat_sel), 0);
    en = 1'b0;
    wait_idle(100);
    chk("busy_after_restart", int'(busy), 0);
    drained();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sar_adc_ctrl.md
# sar_adc_ctrl

Successive-approximation controller that sits directly upstream of the feature shift register. It sequences the analog feature mux, the sample/hold, and the N-bit capacitive DAC. It resolves one N-bit quantized feature per N+1 clock cycles from a 1-bit comparator. A full frame of NUM_FEAT features produces NUM_FEAT `feat_valid` pulses, each carrying a `quant_feat` word for the downstream shift register.

## Interface
- `N`, 4: bits per feature (DAC/result width), ≥2
- `NUM_FEAT`, 10: features per frame, ≥2
- `SAR_CYCLES`, N+1 (derived, not overridable): cycles per feature (1 sample + N decisions)

- `clk`  in  1  system clock
- `rst_n`  in  1  reset; synchronous, active-low
- `en`  in  1  start/continue request; sampled only in IDLE and at frame end
- `cmp_in`  in  1  comparator result for current `dac_code`; 1 = analog input ≥ DAC level
- `sample`  out  1  track/hold control; 1 = tracking input
- `dac_code`  out  N  DAC trial code
- `feat_sel`  out  $clog2(NUM_FEAT)  analog mux select, index of feature being converted
- `quant_feat`  out  N  last resolved feature value
- `feat_valid`  out  1  one-cycle pulse; `quant_feat` newly updated
- `frame_done`  out  1  one-cycle pulse, coincident with `feat_valid` of feature NUM_FEAT-1
- `busy`  out  1  high in SAMPLE and CONVERT

## Operation
- Internal registers: state {IDLE, SAMPLE, CONVERT}, `bit_idx` ($clog2(N) bits), `acc` (N bits), `feat_sel`.
- IDLE: `sample`=0, `dac_code`=0, `busy`=0.
  - If `en`=1, go to SAMPLE with `feat_sel`<=0.
- SAMPLE (1 cycle): `sample`=1, `dac_code`=0.
  - Next: CONVERT with `bit_idx`<=N-1 and `acc`<=0.
- CONVERT (N cycles): `dac_code` = `acc` | (1<<`bit_idx`), combinational from registers. `sample`=0.
  - Each edge: `acc[bit_idx]`<=`cmp_in`, and `bit_idx` decrements.
- Last decision, when `bit_idx`==0:
  - `quant_feat` <= {`acc`[N-1:1], `cmp_in`}.
  - `feat_valid` asserts on the next cycle.
  - If `feat_sel`<NUM_FEAT-1: `feat_sel`++, go to SAMPLE.
  - If `feat_sel`==NUM_FEAT-1: `frame_done` asserts on the next cycle.
    - If `en`=1, go to SAMPLE with `feat_sel`<=0 (back-to-back frames, no gap).
    - Otherwise go to IDLE; `feat_sel` holds at NUM_FEAT-1.
- `en` deasserting mid-frame does not abort. The frame always completes.
- `quant_feat` holds its value between `feat_valid` pulses.
- `feat_valid` and `frame_done` are registered pulses, never longer than 1 cycle.

## Timing
- Reset (`rst_n`=0 at an edge), in any state, including mid-CONVERT: state=IDLE, `acc`=0, `bit_idx`=0, `feat_sel`=0, `quant_feat`=0, `feat_valid`=0, `frame_done`=0.
  - Resulting outputs: `sample`=0, `dac_code`=0, `busy`=0.
  - No partial result is emitted.
- Let edge t0 be the edge where `en`=1 is sampled in IDLE. Then:
  - SAMPLE occupies cycle t0..t0+1.
  - CONVERT occupies cycles t0+1..t0+N+1.
  - `feat_valid` is high in cycle t0+N+1..t0+N+2, concurrent with SAMPLE of the next feature.
- Feature k result: `feat_valid` at t0+(k+1)(N+1). Frame length is NUM_FEAT·(N+1) cycles.
- `cmp_in` must settle within the same cycle `dac_code` is presented. It is sampled at that cycle's closing edge.
- `feat_sel` changes only at the edge leaving the last CONVERT cycle. It is stable through SAMPLE and CONVERT.

## Test plan
- Comparator model `cmp_in` = (vin ≥ `dac_code`), N=4, vin=11, single frame, `en` pulsed once:
  - required: `dac_code` sequence 8,12,10,11;
  - `quant_feat`=11 with `feat_valid` at t0+5.
- Full frame, NUM_FEAT=10, vin = (`feat_sel`·3+1) mod 16:
  - required: 10 `feat_valid` pulses spaced 5 cycles apart, values 1,4,7,10,13,0,3,6,9,12;
  - `frame_done` only with the 10th pulse;
  - `busy` low afterwards with `en`=0.
- Extremes:
  - vin=0 → `dac_code` 8,4,2,1 and `quant_feat`=0;
  - vin=15 → `dac_code` 8,12,14,15 and `quant_feat`=15.
- `en` held high:
  - required: second frame's SAMPLE (`feat_sel`=0) starts in the same cycle as the first `frame_done`; no idle cycle.
- `en` dropped after the 3rd feature:
  - required: frame still completes all 10 features, then IDLE.
- `rst_n`=0 for 1 cycle during CONVERT of feature 4:
  - required: next cycle IDLE, all outputs 0, no `feat_valid`;
  - a later `en` restarts at `feat_sel`=0.
